// File: rtl/gdu.sv
// gdu -- generalized data unpacker.
//
// Takes an N*M-bit packed word carrying 1..M valid low slices and plays
// it out as N-bit slices, one per accepted output cycle. The output side
// is fully registered: valid_dout, dout and last_dout come straight from
// flops, so there is no combinational path from valid_din to the output.
// The only combinational input-to-output path is ready_dout -> ready_din.
// That path is live only on the last slice of a word, and it lets the next
// word load with no idle cycle between words.
//
// Configuration macro: GDU_MSB_FIRST_EN
//   undefined : slices leave in order 0, 1, .., len-1
//   defined   : slices leave in order len-1 down to 0
//
// Parameters
//   N      slice width (narrow bus)
//   M      slices per packed word (M >= 2)
//   LOG2M  ceil(log2(M)); width of the slice counter and len_din
//
// Ports
//   clk         clock, rising edge
//   reset       asynchronous, active-high
//   din         packed input word, N*M bits
//   len_din     valid low slices in din; 0 or any value >= M means M
//   valid_din   din/len_din valid
//   ready_din   unpacker accepts din this cycle
//   dout        current slice
//   valid_dout  dout valid
//   ready_dout  consumer accepts dout
//   last_dout   dout is the final slice of the current word
module gdu #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int LOG2M = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N*M-1:0]   din,
  input  logic [LOG2M-1:0] len_din,
  input  logic             valid_din,
  output logic             ready_din,
  output logic [N-1:0]     dout,
  output logic             valid_dout,
  input  logic             ready_dout,
  output logic             last_dout
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam logic [LOG2M:0] LEN_FULL = (LOG2M+1)'(M);
  localparam logic [LOG2M:0] LEN_ONE  = (LOG2M+1)'(1);

  state_t           state_q, state_d;
  logic [N*M-1:0]   hold_q, hold_d;
  logic [LOG2M-1:0] cnt_q, cnt_d;
  logic [LOG2M:0]   len_q, len_d;
  logic [N-1:0]     dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;

  logic             out_xfer;
  logic             in_xfer;
  logic             load;
  logic [LOG2M:0]   len_in;
  logic [LOG2M-1:0] sel_d;
  logic [N-1:0]     slice_d [M];

  // The word can be replaced in the same cycle its last slice is taken.
  assign out_xfer  = valid_q & ready_dout;
  assign ready_din = (state_q == IDLE) | (out_xfer & last_q);
  assign in_xfer   = valid_din & ready_din;

  // When M is not a power of two, len_din can hold values >= M.
  // Those values, and 0, mean a full word.
  assign len_in = ((len_din == '0) || ({1'b0, len_din} >= LEN_FULL))
                  ? LEN_FULL : {1'b0, len_din};

  // Split the next hold value into its slices.
  // The output mux then selects a whole slice.
  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_slice
      assign slice_d[gi] = hold_d[gi*N +: N];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    load    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_xfer) load = 1'b1;
      end
      SHIFT: begin
        if (out_xfer) begin
          if (!last_q)        cnt_d   = cnt_q + LOG2M'(1);
          else if (valid_din) load    = 1'b1;
          else                state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      hold_d  = din;
      cnt_d   = '0;
      len_d   = len_in;
      state_d = SHIFT;
    end

    // Compute the output flops from the next state.
    // This keeps the outputs aligned with hold/cnt without any input feed-through.
`ifdef GDU_MSB_FIRST_EN
    sel_d = LOG2M'(len_d - LEN_ONE - {1'b0, cnt_d});
`else
    sel_d = cnt_d;
`endif
    valid_d = (state_d == SHIFT);
    dout_d  = valid_d ? slice_d[sel_d] : '0;
    last_d  = valid_d & ({1'b0, cnt_d} == (len_d - LEN_ONE));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign dout       = dout_q;
  assign valid_dout = valid_q;
  assign last_dout  = last_q;

endmodule
